// File: rtl/test_monitor.sv
// Purpose : sequences CPU self-test checkpoints against an ordered expected-value table,
//           drives pass/fail LEDs and flags a hung CPU through a watchdog.
// Latency : 1 cycle from temp_trg to led_g/led_r/done/fail_*; backpressure: none, every strobe is consumed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   temp_out, temp_trg  CPU checkpoint word and its one-cycle strobe
//   chk_idx -> exp_val  lookup address out, combinational table value back in
//   led_g, led_r, done  pass / fail / finished indicators
//   fail_tmo, fail_idx, fail_val  failure cause, index and captured word (0 on timeout)
//
// Optional feature: define TEST_MON_BLINK_EN to make led_r blink with a half-period of
// BLINK_DIV cycles while in FAIL. Without it led_r is steady and no divider exists.
module test_monitor #(
    parameter int NUM_CHK   = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = 1000000,
    parameter int CNT_W     = 24,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      temp_out,
    input  logic             temp_trg,
    output logic [IDX_W-1:0] chk_idx,
    input  logic [31:0]      exp_val,
    output logic             led_g,
    output logic             led_r,
    output logic             done,
    output logic             fail_tmo,
    output logic [IDX_W-1:0] fail_idx,
    output logic [31:0]      fail_val
);

    // Elaboration-time parameter sanity checks.
    generate
        if (NUM_CHK < 1 || NUM_CHK > (1 << IDX_W)) begin : g_bad_num_chk
            $error("test_monitor: NUM_CHK must be in 1..2**IDX_W");
        end
        if (longint'(TIMEOUT) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
            $error("test_monitor: CNT_W too narrow to hold TIMEOUT-1");
        end
        if (BLINK_DIV < 1) begin : g_bad_blink_div
            $error("test_monitor: BLINK_DIV must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHK - 1);
    localparam bit               WDOG_EN  = (TIMEOUT != 0);
    // With the watchdog disabled the compare value is irrelevant; keep it a clean zero.
    localparam logic [CNT_W-1:0] WDOG_MAX = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wdog;

    logic running;
    logic hit;
    logic miss;
    logic tmo;
    logic last;

    assign running = (state == ST_RUN);
    assign hit     = running & temp_trg & (temp_out == exp_val);
    assign miss    = running & temp_trg & (temp_out != exp_val);
    // A strobe in the final idle cycle suppresses the timeout: trigger wins.
    assign tmo     = running & ~temp_trg & WDOG_EN & (wdog == WDOG_MAX);
    assign last    = (chk_idx == LAST_IDX);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (hit && last) begin
                    state_nxt = ST_PASS;
                end else if (miss || tmo) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_PASS: state_nxt = ST_PASS;
            ST_FAIL: state_nxt = ST_FAIL;
            default: state_nxt = ST_RUN;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // Index, watchdog and failure record only move while running; in PASS/FAIL
    // they freeze so the board shows where the sequence ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_idx  <= '0;
            wdog     <= '0;
            fail_tmo <= 1'b0;
            fail_idx <= '0;
            fail_val <= '0;
        end else if (running) begin
            if (hit) begin
                wdog <= '0;
                if (!last) begin
                    chk_idx <= chk_idx + IDX_W'(1);
                end
            end else if (miss) begin
                fail_tmo <= 1'b0;
                fail_idx <= chk_idx;
                fail_val <= temp_out;
            end else if (tmo) begin
                fail_tmo <= 1'b1;
                fail_idx <= chk_idx;
                fail_val <= '0;
            end else if (WDOG_EN) begin
                wdog <= wdog + CNT_W'(1);
            end
        end
    end

`ifdef TEST_MON_BLINK_EN
    localparam int               BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_DIV - 1);

    logic             blink_q;
    logic [BLK_W-1:0] blink_cnt;

    // Held at phase start (led on, count 0) outside FAIL, so the first FAIL
    // cycle always shows the LED lit for a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (state != ST_FAIL) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_q   <= ~blink_q;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end
`else
    logic blink_q;
    assign blink_q = 1'b1;
`endif

    // ---------------------------------------------------------------- outputs
    // Decoded from the registered state, so they change on the edge that ends
    // the strobe cycle.
    always_comb begin
        led_g = 1'b0;
        led_r = 1'b0;
        done  = 1'b0;
        case (state)
            ST_PASS: begin
                led_g = 1'b1;
                done  = 1'b1;
            end
            ST_FAIL: begin
                led_r = blink_q;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_test_monitor.sv
// Purpose : directed self-checking bench for test_monitor (NUM_CHK=3, TIMEOUT=16, BLINK_DIV=4)
//           plus a watchdog-disabled instance sharing the same stimulus.
// Latency : outputs sampled 1 time unit after the clock edge that ends each strobe cycle.
module tb_test_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] temp_out;
    logic        temp_trg;

    logic [1:0]  chk_idx, fail_idx;
    logic [31:0] exp_val, fail_val;
    logic        led_g, led_r, done, fail_tmo;

    logic [1:0]  chk_idx_nw, fail_idx_nw;
    logic [31:0] exp_val_nw, fail_val_nw;
    logic        led_g_nw, led_r_nw, done_nw, fail_tmo_nw;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [8:0] blink_pat;

    function automatic logic [31:0] tbl(input logic [1:0] i);
        case (i)
            2'd0:    return 32'h0000_0001;
            2'd1:    return 32'h0000_0002;
            2'd2:    return 32'h0000_4038;
            default: return 32'h0000_0000;
        endcase
    endfunction

    assign exp_val    = tbl(chk_idx);
    assign exp_val_nw = tbl(chk_idx_nw);

    test_monitor #(
        .NUM_CHK(3), .IDX_W(2), .TIMEOUT(16), .CNT_W(24), .BLINK_DIV(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .temp_out(temp_out), .temp_trg(temp_trg),
        .chk_idx(chk_idx), .exp_val(exp_val), .led_g(led_g), .led_r(led_r),
        .done(done), .fail_tmo(fail_tmo), .fail_idx(fail_idx), .fail_val(fail_val)
    );

    test_monitor #(
        .NUM_CHK(3), .IDX_W(2), .TIMEOUT(0), .CNT_W(24), .BLINK_DIV(4)
    ) u_nowd (
        .clk(clk), .rst_n(rst_n), .temp_out(temp_out), .temp_trg(temp_trg),
        .chk_idx(chk_idx_nw), .exp_val(exp_val_nw), .led_g(led_g_nw), .led_r(led_r_nw),
        .done(done_nw), .fail_tmo(fail_tmo_nw), .fail_idx(fail_idx_nw), .fail_val(fail_val_nw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] v);
        temp_out = v;
        temp_trg = 1'b1;
        tick(1);
        temp_trg = 1'b0;
        temp_out = 32'h0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
`ifdef TEST_MON_BLINK_EN
        blink_pat = 9'b1_0000_1111;
`else
        blink_pat = 9'b1_1111_1111;
`endif
        rst_n    = 1'b0;
        temp_trg = 1'b0;
        temp_out = 32'h0;
        tick(2);

        // Reset state
        check("rst_chk_idx",  chk_idx,  0);
        check("rst_led_g",    led_g,    0);
        check("rst_led_r",    led_r,    0);
        check("rst_done",     done,     0);
        check("rst_fail_tmo", fail_tmo, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_fail_val", fail_val, 0);
        rst_n = 1'b1;

        // Good sequence, strobes 5 cycles apart
        strobe(32'h0000_0001);
        check("pass_idx1", chk_idx, 1);
        check("pass_done_early", done, 0);
        tick(4);
        strobe(32'h0000_0002);
        check("pass_idx2", chk_idx, 2);
        tick(4);
        check("pass_led_g_early", led_g, 0);
        strobe(32'h0000_4038);
        check("pass_led_g", led_g, 1);
        check("pass_led_r", led_r, 0);
        check("pass_done",  done,  1);
        check("pass_idx_hold", chk_idx, 2);
        check("pass_nowd_led_g", led_g_nw, 1);
        // PASS is sticky: bad strobe and long silence change nothing
        strobe(32'hDEAD_BEEF);
        tick(20);
        check("pass_sticky_led_g", led_g, 1);
        check("pass_sticky_led_r", led_r, 0);
        check("pass_sticky_idx", chk_idx, 2);

        // Asynchronous reset takes effect before the next edge
        rst_n = 1'b0;
        #1;
        check("arst_led_g", led_g, 0);
        check("arst_done",  done,  0);
        check("arst_idx",   chk_idx, 0);
        tick(1);
        rst_n = 1'b1;

        // Value mismatch at index 1
        strobe(32'h0000_0001);
        tick(4);
        strobe(32'h0000_0003);
        check("mis_led_r",    led_r,    1);
        check("mis_led_g",    led_g,    0);
        check("mis_done",     done,     1);
        check("mis_fail_tmo", fail_tmo, 0);
        check("mis_fail_idx", fail_idx, 1);
        check("mis_fail_val", fail_val, 32'h0000_0003);
        tick(2);
        strobe(32'h0000_0002);
        check("mis_ignore_val", fail_val, 32'h0000_0003);
        check("mis_ignore_idx", chk_idx, 1);

        // Mismatch at index 0: led_r pattern from FAIL entry
        pulse_reset();
        strobe(32'h0000_0005);
        check("mis0_fail_idx", fail_idx, 0);
        check("mis0_fail_val", fail_val, 32'h0000_0005);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("blink_%0d", i), led_r, blink_pat[i]);
            check($sformatf("blink_g_%0d", i), led_g, 0);
            tick(1);
        end

        // Watchdog: one good strobe then silence, FAIL 16 cycles after the strobe
        pulse_reset();
        strobe(32'h0000_0001);
        tick(15);
        check("tmo_done_early", done, 0);
        tick(1);
        check("tmo_done",     done,     1);
        check("tmo_led_r",    led_r,    1);
        check("tmo_fail_tmo", fail_tmo, 1);
        check("tmo_fail_idx", fail_idx, 1);
        check("tmo_fail_val", fail_val, 0);
        check("nowd_done",    done_nw,  0);
        check("nowd_idx",     chk_idx_nw, 1);

        // Strobe in the 16th idle cycle beats the timeout
        pulse_reset();
        strobe(32'h0000_0001);
        tick(15);
        strobe(32'h0000_0002);
        check("race_done", done, 0);
        check("race_idx",  chk_idx, 2);
        tick(10);
        check("race_wdog_cleared", done, 0);

        // Reset mid-sequence, then a full pass from index 0
        rst_n = 1'b0;
        #1;
        check("mid_rst_idx",  chk_idx, 0);
        check("mid_rst_done", done, 0);
        tick(1);
        rst_n = 1'b1;
        strobe(32'h0000_0001);
        check("rerun_idx1", chk_idx, 1);
        tick(4);
        strobe(32'h0000_0002);
        tick(4);
        strobe(32'h0000_4038);
        check("rerun_led_g", led_g, 1);
        check("rerun_done",  done,  1);
        check("rerun_led_r", led_r, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
